even_odd_stream_checker: RTL and testbench
==========================================

// Module: even_odd_stream_checker
// PURPOSE
//  Streaming, parametrised successor to the combinational 8-bit even/odd checker.
//  Accepts WIDTH-bit words on a valid/ready input and tags each word even/odd plus its XOR parity.
//  Returns each tagged word through a registered valid/ready output.
//  Tallies even/odd counts over a window of WINDOW accepted words, then presents a summary record.
//  Sits between a data source and the stats/debug collector.
// PARAMETERS
//  WIDTH   8   data word width, >=1
//  WINDOW  16  accepted words per summary window, >=1
//  CW      $clog2(WINDOW+1)  derived count width (localparam, not overridable)
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  clear         in   1      sync: abort window, zero counters
//  in_valid      in   1      input word valid
//  in_ready      out  1      input can accept
//  in_data       in   WIDTH  input word
//  out_valid     out  1      tagged word valid
//  out_ready     in   1      downstream accepts tagged word
//  out_data      out  WIDTH  registered copy of in_data
//  out_even      out  1      ~in_data[0]
//  out_odd       out  1      in_data[0]
//  out_parity    out  1      ^in_data (1 = odd number of ones)
//  sum_valid     out  1      window summary valid
//  sum_ready     in   1      summary consumed
//  sum_even_cnt  out  CW     even words in finished window
//  sum_odd_cnt   out  CW     odd words in finished window
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready. in_ready=1 one cycle after rst falls. FSM=COUNT, counters=0.
//  Accept: beat fires when in_valid & in_ready.
//  Output stage: 1-deep register, 1-cycle latency, no bubbles.
//   in_ready = (state==COUNT) & (~out_valid | out_ready).
//   out_* load on accept; out_valid drops when out_ready & no new accept.
//   out_* hold stable while out_valid & ~out_ready.
//  out_even/out_odd always mutually exclusive when out_valid=1.
//  FSM COUNT:
//   Each accept increments even_cnt or odd_cnt by in_data[0].
//   The accept that makes even_cnt+odd_cnt==WINDOW moves FSM to REPORT.
//   sum_* register the final counts, including that beat.
//  FSM REPORT:
//   sum_valid=1, in_ready=0.
//   Output stage may still drain its held word.
//   On sum_ready: counters->0, sum_valid->0, FSM->COUNT next cycle.
//  Summary invariant: sum_even_cnt+sum_odd_cnt == WINDOW. Counters never wrap.
//  clear in COUNT:
//   Counters zeroed.
//   An accept in the same cycle counts as the first word of the new window (count=1).
//  clear in REPORT: summary dropped, sum_valid->0, FSM->COUNT.
//  clear leaves the output register untouched.
//  WINDOW=1: every accept moves FSM to REPORT.
//  rst mid-window or mid-REPORT: immediate return to reset state. In-flight word and summary lost.
// CONFIGURATION
//  EVEN_ODD_PARITY_ERR_EN defined adds:
//   in_exp_parity  in   1   expected parity, sampled with in_data
//   out_par_err    out  1   registered (^in_data != in_exp_parity), aligned with out_data
//   sum_err_cnt    out  CW  parity errors in the window, same clear/report rules
//  EVEN_ODD_PARITY_ERR_EN undefined: the three ports above do not exist.
//  All other behaviour is identical with or without the macro.
// STRUCTURE
//  Package even_odd_pkg:
//   typedef enum {COUNT, REPORT} eo_state_t
//   function cnt_width(window) returning $clog2(window+1)
//  Sub-module eo_window_counter (WINDOW):
//   Inputs: inc_even, inc_odd, clear.
//   Outputs: even_cnt, odd_cnt, done.
//   Instantiated once. Reused for the error count when EVEN_ODD_PARITY_ERR_EN is defined.
// TESTING
//  WIDTH=8, WINDOW=4 unless stated.
//  1. Reset: rst=1 mid-stream, then release -> all outputs 0; in_ready=1 one cycle later; counters 0.
//  2. Words 2,3,8,15, out_ready=1 ->
//     out_even/out_odd = 1/0, 0/1, 1/0, 0/1; out_parity = 1,0,1,0; each one cycle after accept.
//     After 4th word: sum_valid=1, even=2, odd=2, in_ready=0.
//     sum_ready=1 -> in_ready=1 next cycle.
//  3. Backpressure: out_ready=0 for 3 cycles after word 0xA5 ->
//     out_data holds 0xA5; in_ready=0; no beat lost or duplicated.
//  4. clear with accept of 7 after words 1,1 ->
//     new window holds odd=1, even=0; summary after 3 further words.
//  5. WINDOW=1, word 0xFF -> summary even=0, odd=1.
//     With EVEN_ODD_PARITY_ERR_EN, in_exp_parity=1 -> out_par_err=1, sum_err_cnt=1.
//  6. Random traffic with random ready, 1000 words ->
//     scoreboard matches every tagged word and every summary against a reference model.

Source files
------------

// File: rtl/even_odd_pkg.sv
// Shared types and helpers for the even/odd stream checker.
//
// Contents:
//   eo_state_t - window FSM state: COUNT (collecting words), REPORT (summary held)
//   cnt_width  - width of a counter that must hold values 0..window inclusive
package even_odd_pkg;

    typedef enum logic {
        COUNT  = 1'b0,
        REPORT = 1'b1
    } eo_state_t;

    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/eo_window_counter.sv
// Two-bucket window counter.
//
// Counts increments into two buckets (even/odd, or error/ok when reused for
// parity errors) and flags the increment that fills the window.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               zero both buckets; an increment in the same cycle
//                       lands on top of the zeroed value (count becomes 1)
//   inc_even, inc_odd   one-hot increment requests
//   even_cnt, odd_cnt   current bucket values
//   done                this cycle's increment brings even+odd to WINDOW
module eo_window_counter
    import even_odd_pkg::*;
#(
    parameter  int WINDOW = 16,
    localparam int CW     = cnt_width(WINDOW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc_even,
    input  logic          inc_odd,
    output logic [CW-1:0] even_cnt,
    output logic [CW-1:0] odd_cnt,
    output logic          done
);

    logic [CW-1:0] base_even;
    logic [CW-1:0] base_odd;
    logic [CW:0]   total_next;

    // Clear acts before the increment so a simultaneous accept opens the
    // new window. total_next carries one spare bit so the compare is exact.
    always_comb begin
        base_even  = clear ? '0 : even_cnt;
        base_odd   = clear ? '0 : odd_cnt;
        total_next = {1'b0, base_even} + {1'b0, base_odd}
                   + (CW+1)'(inc_even) + (CW+1)'(inc_odd);
        done       = (inc_even || inc_odd) && (total_next == (CW+1)'(WINDOW));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            even_cnt <= '0;
            odd_cnt  <= '0;
        end else begin
            even_cnt <= base_even + CW'(inc_even);
            odd_cnt  <= base_odd  + CW'(inc_odd);
        end
    end

endmodule

// File: rtl/even_odd_stream_checker.sv
// Streaming even/odd checker with windowed summary.
//
// Accepts WIDTH-bit words on a valid/ready input, tags each with even/odd and
// XOR parity, and returns it through a 1-deep registered valid/ready output.
// Every WINDOW accepted words it stops accepting and presents even/odd
// totals on a summary valid/ready port until consumed or cleared.
//
// Handshake rule (all three ports): a transfer happens on a rising clk edge
// where valid and ready are both 1; a producer holds valid and its payload
// stable until that edge, and ready never depends on the same port's valid.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   clear                    abort current window (or drop a pending summary)
//   in_valid/in_ready/in_data            input stream
//   out_valid/out_ready/out_data         tagged output stream
//   out_even/out_odd/out_parity          tags aligned with out_data
//   sum_valid/sum_ready                  window summary handshake
//   sum_even_cnt/sum_odd_cnt             totals of the finished window
//
// Optional build macro EVEN_ODD_PARITY_ERR_EN adds:
//   in_exp_parity  expected parity, sampled with in_data
//   out_par_err    parity mismatch flag aligned with out_data
//   sum_err_cnt    parity mismatches in the finished window
module even_odd_stream_checker
    import even_odd_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int WINDOW = 16,
    localparam int CW     = cnt_width(WINDOW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_even,
    output logic             out_odd,
    output logic             out_parity,
`ifdef EVEN_ODD_PARITY_ERR_EN
    input  logic             in_exp_parity,
    output logic             out_par_err,
    output logic [CW-1:0]    sum_err_cnt,
`endif
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [CW-1:0]    sum_even_cnt,
    output logic [CW-1:0]    sum_odd_cnt
);

    eo_state_t     state_q;
    eo_state_t     state_d;
    logic          started_q;
    logic          fire;
    logic          ctr_clear;
    logic          win_done;
    logic [CW-1:0] even_cnt;
    logic [CW-1:0] odd_cnt;

    // in_ready is held low during reset and for the first cycle after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) started_q <= 1'b0;
        else     started_q <= 1'b1;
    end

    assign fire = in_valid && in_ready;

    // Counters are zeroed by clear in either state, and by consuming the
    // summary. In REPORT no accept can occur, so the count is frozen there.
    assign ctr_clear = clear || ((state_q == REPORT) && sum_ready);

    eo_window_counter #(.WINDOW(WINDOW)) u_win_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (ctr_clear),
        .inc_even (fire && !in_data[0]),
        .inc_odd  (fire &&  in_data[0]),
        .even_cnt (even_cnt),
        .odd_cnt  (odd_cnt),
        .done     (win_done)
    );

`ifdef EVEN_ODD_PARITY_ERR_EN
    logic          par_err_now;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] err_ok_unused;
    logic          err_done_unused;

    assign par_err_now = (^in_data) != in_exp_parity;

    // Same window rules as the even/odd count: buckets are error / no-error.
    eo_window_counter #(.WINDOW(WINDOW)) u_err_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (ctr_clear),
        .inc_even (fire &&  par_err_now),
        .inc_odd  (fire && !par_err_now),
        .even_cnt (err_cnt),
        .odd_cnt  (err_ok_unused),
        .done     (err_done_unused)
    );
`endif

    // Window FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= COUNT;
        else     state_q <= state_d;
    end

    // Next state and window-side outputs.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        sum_valid    = 1'b0;
        sum_even_cnt = '0;
        sum_odd_cnt  = '0;
`ifdef EVEN_ODD_PARITY_ERR_EN
        sum_err_cnt  = '0;
`endif
        case (state_q)
            COUNT: begin
                in_ready = started_q && (!out_valid || out_ready);
                if (fire && win_done) state_d = REPORT;
            end
            REPORT: begin
                sum_valid    = 1'b1;
                sum_even_cnt = even_cnt;
                sum_odd_cnt  = odd_cnt;
`ifdef EVEN_ODD_PARITY_ERR_EN
                sum_err_cnt  = err_cnt;
`endif
                if (clear || sum_ready) state_d = COUNT;
            end
            default: state_d = COUNT;
        endcase
    end

    // 1-deep output register: loads on every accept, empties when taken
    // without a replacement, holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_even   <= 1'b0;
            out_odd    <= 1'b0;
            out_parity <= 1'b0;
`ifdef EVEN_ODD_PARITY_ERR_EN
            out_par_err <= 1'b0;
`endif
        end else if (fire) begin
            out_valid  <= 1'b1;
            out_data   <= in_data;
            out_even   <= !in_data[0];
            out_odd    <= in_data[0];
            out_parity <= ^in_data;
`ifdef EVEN_ODD_PARITY_ERR_EN
            out_par_err <= par_err_now;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_even_odd_stream_checker.sv
// Self-checking bench for even_odd_stream_checker.
// Main DUT: WIDTH=8, WINDOW=4. Second DUT: WINDOW=1.
module tb_even_odd_stream_checker;

    localparam int CW4 = 3;
    localparam int CW1 = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (WINDOW=4) ----------------
    logic           clear = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [7:0]     in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [7:0]     out_data;
    logic           out_even;
    logic           out_odd;
    logic           out_parity;
    logic           sum_valid;
    logic           sum_ready = 1'b0;
    logic [CW4-1:0] sum_even_cnt;
    logic [CW4-1:0] sum_odd_cnt;
`ifdef EVEN_ODD_PARITY_ERR_EN
    logic           in_exp_parity;
    logic           out_par_err;
    logic [CW4-1:0] sum_err_cnt;
    assign in_exp_parity = ^in_data;
`endif

    even_odd_stream_checker #(.WIDTH(8), .WINDOW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_even     (out_even),
        .out_odd      (out_odd),
        .out_parity   (out_parity),
`ifdef EVEN_ODD_PARITY_ERR_EN
        .in_exp_parity(in_exp_parity),
        .out_par_err  (out_par_err),
        .sum_err_cnt  (sum_err_cnt),
`endif
        .sum_valid    (sum_valid),
        .sum_ready    (sum_ready),
        .sum_even_cnt (sum_even_cnt),
        .sum_odd_cnt  (sum_odd_cnt)
    );

    // ---------------- second DUT (WINDOW=1) ----------------
    logic           w1_clear = 1'b0;
    logic           w1_in_valid = 1'b0;
    logic           w1_in_ready;
    logic [7:0]     w1_in_data = '0;
    logic           w1_out_valid;
    logic           w1_out_ready = 1'b1;
    logic [7:0]     w1_out_data;
    logic           w1_out_even;
    logic           w1_out_odd;
    logic           w1_out_parity;
    logic           w1_sum_valid;
    logic           w1_sum_ready = 1'b0;
    logic [CW1-1:0] w1_sum_even_cnt;
    logic [CW1-1:0] w1_sum_odd_cnt;
`ifdef EVEN_ODD_PARITY_ERR_EN
    logic           w1_in_exp_parity = 1'b0;
    logic           w1_out_par_err;
    logic [CW1-1:0] w1_sum_err_cnt;
`endif

    even_odd_stream_checker #(.WIDTH(8), .WINDOW(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .clear        (w1_clear),
        .in_valid     (w1_in_valid),
        .in_ready     (w1_in_ready),
        .in_data      (w1_in_data),
        .out_valid    (w1_out_valid),
        .out_ready    (w1_out_ready),
        .out_data     (w1_out_data),
        .out_even     (w1_out_even),
        .out_odd      (w1_out_odd),
        .out_parity   (w1_out_parity),
`ifdef EVEN_ODD_PARITY_ERR_EN
        .in_exp_parity(w1_in_exp_parity),
        .out_par_err  (w1_out_par_err),
        .sum_err_cnt  (w1_sum_err_cnt),
`endif
        .sum_valid    (w1_sum_valid),
        .sum_ready    (w1_sum_ready),
        .sum_even_cnt (w1_sum_even_cnt),
        .sum_odd_cnt  (w1_sum_odd_cnt)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [7:0]       exp_q[$];
    logic [2*CW4-1:0] sum_q[$];
    int model_even = 0;
    int model_odd  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference window model, called once per accepted beat.
    task automatic model_accept(input logic [7:0] d, input logic clr);
        if (clr) begin
            model_even = 0;
            model_odd  = 0;
        end
        if (d[0]) model_odd++;
        else      model_even++;
        exp_q.push_back(d);
        if (model_even + model_odd == 4) begin
            sum_q.push_back({CW4'(model_even), CW4'(model_odd)});
            model_even = 0;
            model_odd  = 0;
        end
    endtask

    // Output beat monitor: inputs only change just after posedge, so the
    // values seen at negedge are those present at the next rising edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("out_data",   32'(out_data),   32'(e));
                check("out_even",   32'(out_even),   32'(!e[0]));
                check("out_odd",    32'(out_odd),    32'(e[0]));
                check("out_parity", 32'(out_parity), 32'(^e));
`ifdef EVEN_ODD_PARITY_ERR_EN
                check("out_par_err", 32'(out_par_err), 32'd0);
`endif
            end
        end
    end

    // Summary monitor.
    always @(negedge clk) begin
        logic [2*CW4-1:0] s;
        if (!rst && sum_valid && sum_ready) begin
            if (sum_q.size() == 0) begin
                check("sum_unexpected", 32'(sum_even_cnt), 32'hFFFF_FFFF);
            end else begin
                s = sum_q.pop_front();
                check("sum_even", 32'(sum_even_cnt), 32'(s[2*CW4-1:CW4]));
                check("sum_odd",  32'(sum_odd_cnt),  32'(s[CW4-1:0]));
`ifdef EVEN_ODD_PARITY_ERR_EN
                check("sum_err", 32'(sum_err_cnt), 32'd0);
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end at posedge + 1.
    task automatic send(input logic [7:0] d, input logic clr);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        clear    = clr;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
            @(posedge clk);
        end else begin
            @(posedge clk);
            model_accept(d, clr);
        end
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic consume_sum();
        sum_ready = 1'b1;
        @(posedge clk);
        #1;
        sum_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        clear = 1'b0;
        w1_in_valid = 1'b0;
        exp_q.delete();
        sum_q.delete();
        model_even = 0;
        model_odd  = 0;
        @(negedge clk);
        check("rst_out_valid",  32'(out_valid),    32'd0);
        check("rst_out_data",   32'(out_data),     32'd0);
        check("rst_out_even",   32'(out_even),     32'd0);
        check("rst_out_odd",    32'(out_odd),      32'd0);
        check("rst_out_parity", 32'(out_parity),   32'd0);
        check("rst_in_ready",   32'(in_ready),     32'd0);
        check("rst_sum_valid",  32'(sum_valid),    32'd0);
        check("rst_sum_even",   32'(sum_even_cnt), 32'd0);
        check("rst_sum_odd",    32'(sum_odd_cnt),  32'd0);
        check("rst_w1_sum_valid", 32'(w1_sum_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready_first_cycle", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rst_in_ready_second_cycle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic       exp_even;
        logic       exp_odd;
        logic       exp_parity;
    } vec_t;

    vec_t vecs[4];

    // ---------------- test sequence ----------------
    initial begin
        int sent;
        int cyc;
        logic f;

        vecs[0] = '{data: 8'd2,  exp_even: 1'b1, exp_odd: 1'b0, exp_parity: 1'b1};
        vecs[1] = '{data: 8'd3,  exp_even: 1'b0, exp_odd: 1'b1, exp_parity: 1'b0};
        vecs[2] = '{data: 8'd8,  exp_even: 1'b1, exp_odd: 1'b0, exp_parity: 1'b1};
        vecs[3] = '{data: 8'd15, exp_even: 1'b0, exp_odd: 1'b1, exp_parity: 1'b0};

        @(posedge clk);
        #1;
        do_reset();

        // 1. reset mid-stream: word held in the output stage, window partial
        out_ready = 1'b0;
        send(8'h11, 1'b0);
        @(negedge clk);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        do_reset();
        out_ready = 1'b1;

        // 2. table-driven tagging, one-cycle latency, window summary
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].data, 1'b0);
            @(negedge clk);
            check("tbl_out_valid",  32'(out_valid),  32'd1);
            check("tbl_out_even",   32'(out_even),   32'(vecs[i].exp_even));
            check("tbl_out_odd",    32'(out_odd),    32'(vecs[i].exp_odd));
            check("tbl_out_parity", 32'(out_parity), 32'(vecs[i].exp_parity));
            if (i < 3) check("tbl_sum_valid_early", 32'(sum_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("win_sum_valid", 32'(sum_valid),    32'd1);
        check("win_sum_even",  32'(sum_even_cnt), 32'd2);
        check("win_sum_odd",   32'(sum_odd_cnt),  32'd2);
        check("win_in_ready",  32'(in_ready),     32'd0);
        @(posedge clk);
        #1;
        consume_sum();
        @(negedge clk);
        check("win_in_ready_after", 32'(in_ready),  32'd1);
        check("win_sum_valid_after", 32'(sum_valid), 32'd0);
        @(posedge clk);
        #1;

        // 3. backpressure: 0xA5 held for 3 stalled cycles
        out_ready = 1'b0;
        send(8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'hA5);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(8'h3C, 1'b0);
        @(posedge clk);
        #1;

        // 4. clear together with accept of 7 after words 1,1
        do_reset();
        send(8'd1, 1'b0);
        send(8'd1, 1'b0);
        send(8'd7, 1'b1);
        send(8'd2, 1'b0);
        send(8'd4, 1'b0);
        @(negedge clk);
        check("clr_sum_valid_early", 32'(sum_valid), 32'd0);
        @(posedge clk);
        #1;
        send(8'd6, 1'b0);
        @(negedge clk);
        check("clr_sum_valid", 32'(sum_valid),    32'd1);
        check("clr_sum_even",  32'(sum_even_cnt), 32'd3);
        check("clr_sum_odd",   32'(sum_odd_cnt),  32'd1);
        @(posedge clk);
        #1;
        consume_sum();

        // clear while REPORT drops the summary
        for (int i = 0; i < 4; i++) send(8'd5, 1'b0);
        @(negedge clk);
        check("rclr_sum_valid", 32'(sum_valid),   32'd1);
        check("rclr_sum_odd",   32'(sum_odd_cnt), 32'd4);
        @(posedge clk);
        #1;
        clear = 1'b1;
        void'(sum_q.pop_back());
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("rclr_sum_valid_after", 32'(sum_valid), 32'd0);
        check("rclr_in_ready_after",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;

        // 5. WINDOW=1 DUT
        w1_in_valid = 1'b1;
        w1_in_data  = 8'hFF;
`ifdef EVEN_ODD_PARITY_ERR_EN
        w1_in_exp_parity = 1'b1;
`endif
        @(negedge clk);
        check("w1_in_ready", 32'(w1_in_ready), 32'd1);
        @(posedge clk);
        #1;
        w1_in_valid = 1'b0;
        @(negedge clk);
        check("w1_out_data",   32'(w1_out_data),     32'hFF);
        check("w1_out_odd",    32'(w1_out_odd),      32'd1);
        check("w1_out_even",   32'(w1_out_even),     32'd0);
        check("w1_out_parity", 32'(w1_out_parity),   32'd0);
        check("w1_sum_valid",  32'(w1_sum_valid),    32'd1);
        check("w1_sum_even",   32'(w1_sum_even_cnt), 32'd0);
        check("w1_sum_odd",    32'(w1_sum_odd_cnt),  32'd1);
        check("w1_in_ready_rep", 32'(w1_in_ready),   32'd0);
`ifdef EVEN_ODD_PARITY_ERR_EN
        check("w1_out_par_err", 32'(w1_out_par_err), 32'd1);
        check("w1_sum_err",     32'(w1_sum_err_cnt), 32'd1);
`endif
        @(posedge clk);
        #1;
        w1_sum_ready = 1'b1;
        @(posedge clk);
        #1;
        w1_sum_ready = 1'b0;
        @(negedge clk);
        check("w1_sum_valid_after", 32'(w1_sum_valid), 32'd0);
        check("w1_in_ready_after",  32'(w1_in_ready),  32'd1);
        @(posedge clk);
        #1;
        w1_in_valid = 1'b1;
        w1_in_data  = 8'h02;
        @(posedge clk);
        #1;
        w1_in_valid = 1'b0;
        @(negedge clk);
        check("w1b_sum_valid", 32'(w1_sum_valid),    32'd1);
        check("w1b_sum_even",  32'(w1_sum_even_cnt), 32'd1);
        check("w1b_sum_odd",   32'(w1_sum_odd_cnt),  32'd0);
`ifdef EVEN_ODD_PARITY_ERR_EN
        check("w1b_out_par_err", 32'(w1_out_par_err), 32'd0);
        check("w1b_sum_err",     32'(w1_sum_err_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        w1_sum_ready = 1'b1;
        @(posedge clk);
        #1;
        w1_sum_ready = 1'b0;

        // 6. random traffic with random ready
        sent = 0;
        cyc  = 0;
        in_valid = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom_range(0, 255));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            sum_ready = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            f = in_valid && in_ready;
            @(posedge clk);
            cyc++;
            if (f) begin
                model_accept(in_data, 1'b0);
                sent++;
            end
            #1;
            if (f) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sum_ready = 1'b1;
        check("rand_words_sent", 32'(sent), 32'd1000);
        repeat (10) @(posedge clk);
        #1;
        sum_ready = 1'b0;
        check("rand_out_drained", 32'(exp_q.size()), 32'd0);
        check("rand_sum_drained", 32'(sum_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
